// File: rtl/i2c_pkg.sv
// Definitions shared by the I2C master and target: one-hot target FSM encoding
// and the R/W bit values carried in the address byte.
package i2c_pkg;

    typedef enum logic [9:0] {
        ST_IDLE      = 10'b00_0000_0001,
        ST_ADDR      = 10'b00_0000_0010,
        ST_ADDR_ACK  = 10'b00_0000_0100,
        ST_REG       = 10'b00_0000_1000,
        ST_REG_ACK   = 10'b00_0001_0000,
        ST_WDATA     = 10'b00_0010_0000,
        ST_WDATA_ACK = 10'b00_0100_0000,
        ST_RDATA     = 10'b00_1000_0000,
        ST_RDATA_ACK = 10'b01_0000_0000,
        ST_IGNORE    = 10'b10_0000_0000
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    function automatic logic [7:0] i2c_addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bus pins plus the synchronous register-file port of the I2C target.
interface i2c_target_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       reg_wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       busy;
    logic       ack_err;

    modport slave (
        input  scl_in, sda_in, reg_rd_data,
        output sda_oe, reg_wr_en, reg_addr, reg_wr_data, busy, ack_err
    );

    modport master (
        output scl_in, sda_in, reg_rd_data,
        input  sda_oe, reg_wr_en, reg_addr, reg_wr_data, busy, ack_err
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA and produces registered single-clk SCL edge and
// START/STOP pulses, three clocks after the pin change (SYNC_STAGES = 2).
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   r_sda;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Reset to the idle-bus level so leaving reset never fakes a START/STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda      <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_hist <= w_scl;
            r_sda_hist <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_hist;
            r_scl_fall <= ~w_scl & r_scl_hist;
            r_start    <= w_scl & r_scl_hist & ~w_sda & r_sda_hist;
            r_stop     <= w_scl & r_scl_hist & w_sda & ~r_sda_hist;
            r_sda      <= w_sda;
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_sda      = r_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, register-pointer byte, auto-incrementing
// writes/reads against an external 256-entry register file. SDA is open-drain.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDRESS = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (bus.scl_in),
        .i_sda      (bus.sda_in),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

    i2c_state_e r_state, w_state_nx;
    logic [2:0] r_bitcnt, w_bitcnt_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic       r_rw, w_rw_nx;
    // Per-state flag: ACK being driven (ACK states), byte fully sent (RDATA),
    // master ACK seen and waiting for the closing fall (RDATA_ACK).
    logic       r_phase, w_phase_nx;
    logic       r_sda_oe, w_sda_oe_nx;
    logic [7:0] r_reg_addr, w_reg_addr_nx;
    logic [7:0] r_wr_data, w_wr_data_nx;
    logic       r_wr_en, w_wr_en_nx;
    logic       r_busy, w_busy_nx;
    logic       r_ack_err, w_ack_err_nx;
    logic [7:0] w_rx_byte;
    logic       w_byte_done;

    assign w_rx_byte   = {r_shift[6:0], w_sda};
    assign w_byte_done = w_scl_rise && (r_bitcnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_rw       <= I2C_RW_WRITE;
            r_phase    <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_reg_addr <= 8'h00;
            r_wr_data  <= 8'h00;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bitcnt   <= w_bitcnt_nx;
            r_shift    <= w_shift_nx;
            r_rw       <= w_rw_nx;
            r_phase    <= w_phase_nx;
            r_sda_oe   <= w_sda_oe_nx;
            r_reg_addr <= w_reg_addr_nx;
            r_wr_data  <= w_wr_data_nx;
            r_wr_en    <= w_wr_en_nx;
            r_busy     <= w_busy_nx;
            r_ack_err  <= w_ack_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_bitcnt_nx   = r_bitcnt;
        w_shift_nx    = r_shift;
        w_rw_nx       = r_rw;
        w_phase_nx    = r_phase;
        w_sda_oe_nx   = r_sda_oe;
        w_reg_addr_nx = r_reg_addr;
        w_wr_data_nx  = r_wr_data;
        w_wr_en_nx    = 1'b0;
        w_busy_nx     = r_busy;
        w_ack_err_nx  = 1'b0;

        if (w_start) begin
            w_state_nx  = ST_ADDR;
            w_bitcnt_nx = 3'd0;
            w_phase_nx  = 1'b0;
            w_sda_oe_nx = 1'b0;
        end else if (w_stop) begin
            w_state_nx  = ST_IDLE;
            w_bitcnt_nx = 3'd0;
            w_phase_nx  = 1'b0;
            w_sda_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
        end else begin
            if (w_scl_rise && (r_state inside {ST_ADDR, ST_REG, ST_WDATA})) begin
                w_shift_nx  = w_rx_byte;
                w_bitcnt_nx = r_bitcnt + 3'd1;
            end

            case (r_state)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (w_byte_done) begin
                        if (w_rx_byte[7:1] == SLV_ADDRESS) begin
                            w_state_nx = ST_ADDR_ACK;
                            w_busy_nx  = 1'b1;
                            w_rw_nx    = w_rx_byte[0];
                        end else begin
                            w_state_nx = ST_IGNORE;
                            w_busy_nx  = 1'b0;
                        end
                    end
                end

                ST_REG: begin
                    if (w_byte_done) begin
                        w_reg_addr_nx = w_rx_byte;
                        w_state_nx    = ST_REG_ACK;
                    end
                end

                ST_WDATA: begin
                    if (w_byte_done) begin
                        w_wr_data_nx = w_rx_byte;
                        w_wr_en_nx   = 1'b1;
                        w_state_nx   = ST_WDATA_ACK;
                    end
                end

                // First fall after the 8th bit pulls SDA; the next fall ends the ACK.
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_phase_nx  = 1'b1;
                            w_sda_oe_nx = 1'b1;
                        end else begin
                            w_phase_nx  = 1'b0;
                            w_sda_oe_nx = 1'b0;
                            w_bitcnt_nx = 3'd0;
                            if (r_state == ST_ADDR_ACK) begin
                                if (r_rw == I2C_RW_READ) begin
                                    w_state_nx  = ST_RDATA;
                                    w_shift_nx  = bus.reg_rd_data;
                                    w_sda_oe_nx = ~bus.reg_rd_data[7];
                                end else begin
                                    w_state_nx = ST_REG;
                                end
                            end else if (r_state == ST_REG_ACK) begin
                                w_state_nx = ST_WDATA;
                            end else begin
                                w_reg_addr_nx = r_reg_addr + 8'd1;
                                w_state_nx    = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            w_phase_nx = 1'b1;
                    end else if (w_scl_fall) begin
                        if (r_phase) begin
                            w_phase_nx  = 1'b0;
                            w_sda_oe_nx = 1'b0;
                            w_state_nx  = ST_RDATA_ACK;
                        end else begin
                            w_shift_nx  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nx = ~r_shift[6];
                        end
                    end
                end

                // Pointer advances on the master's ACK; next byte loads at the closing fall.
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_reg_addr_nx = r_reg_addr + 8'd1;
                            w_phase_nx    = 1'b1;
                        end else begin
                            w_ack_err_nx = 1'b1;
                            w_sda_oe_nx  = 1'b0;
                            w_busy_nx    = 1'b0;
                            w_state_nx   = ST_IGNORE;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_phase_nx  = 1'b0;
                        w_bitcnt_nx = 3'd0;
                        w_shift_nx  = bus.reg_rd_data;
                        w_sda_oe_nx = ~bus.reg_rd_data[7];
                        w_state_nx  = ST_RDATA;
                    end
                end

                ST_IGNORE: begin
                    w_busy_nx   = 1'b0;
                    w_sda_oe_nx = 1'b0;
                end

                default: begin
                    w_state_nx  = ST_IDLE;
                    w_sda_oe_nx = 1'b0;
                    w_busy_nx   = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe      = r_sda_oe;
    assign bus.reg_wr_en   = r_wr_en;
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wr_data = r_wr_data;
    assign bus.busy        = r_busy;
    assign bus.ack_err     = r_ack_err;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, behavioural register-file model
// and directed plus random write/read-back transactions.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_target_if bus ();

    logic [7:0] mem [256];

    assign bus.scl_in      = scl_m;
    assign bus.sda_in      = sda_m & ~bus.sda_oe;
    assign bus.reg_rd_data = mem[bus.reg_addr];

    i2c_target #(
        .SLV_ADDRESS (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.reg_wr_en) mem[bus.reg_addr] <= bus.reg_wr_data;

    logic [15:0] wr_log [$];
    int ack_err_cnt = 0;
    int oe_cnt      = 0;
    int glitch_cnt  = 0;
    logic prev_oe   = 1'b0;
    logic prev_scl  = 1'b1;

    always @(negedge clk) begin
        if (bus.reg_wr_en) wr_log.push_back({bus.reg_addr, bus.reg_wr_data});
        if (bus.ack_err) ack_err_cnt <= ack_err_cnt + 1;
        if (bus.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
        if (!rst && (bus.sda_oe !== prev_oe) && scl_m && prev_scl) glitch_cnt <= glitch_cnt + 1;
        prev_oe  <= bus.sda_oe;
        prev_scl <= scl_m;
    end

    int n_vec = 0;
    int n_err = 0;
    int rd_idx = 0;
    logic [7:0] model_mem [256];
    logic [7:0] tx_data [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        clks(2); sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q); sda_m = 1'b0; clks(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(2); sda_m = 1'b0; clks(Q); scl_m = 1'b1; clks(Q); sda_m = 1'b1; clks(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            clks(2); sda_m = b[i]; clks(Q - 2); scl_m = 1'b1; clks(Q); scl_m = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        clks(2); sda_m = 1'b1; clks(Q - 2); scl_m = 1'b1; clks(Q / 2);
        ack = ~bus.sda_in;
        clks(Q / 2); scl_m = 1'b0;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            clks(2); sda_m = 1'b1; clks(Q - 2); scl_m = 1'b1; clks(Q / 2);
            b[i] = bus.sda_in;
            clks(Q / 2); scl_m = 1'b0;
        end
        clks(2); sda_m = nack; clks(Q - 2); scl_m = 1'b1; clks(Q); scl_m = 1'b0;
    endtask

    task automatic chk_wr(input logic [7:0] a, input logic [7:0] d);
        if (rd_idx < wr_log.size()) begin
            chk("wr_entry", 32'(wr_log[rd_idx]), {16'h0, a, d});
            rd_idx++;
        end else begin
            chk("wr_missing", 32'(wr_log.size()), 32'(rd_idx + 1));
        end
    endtask

    // Pointer byte then n data bytes from tx_data; model: mem[ptr+i] = data, pointer ends at ptr+n.
    task automatic write_txn(input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] p;
        i2c_start();
        send_byte(i2c_addr_byte(7'h50, I2C_RW_WRITE), ack); chk("wr_addr_ack", 32'(ack), 1);
        chk("wr_busy", 32'(bus.busy), 1);
        send_byte(ptr, ack); chk("wr_ptr_ack", 32'(ack), 1);
        for (int i = 0; i < n; i++) begin
            send_byte(tx_data[i], ack); chk("wr_data_ack", 32'(ack), 1);
        end
        i2c_stop();
        p = ptr;
        for (int i = 0; i < n; i++) begin
            chk_wr(p, tx_data[i]);
            model_mem[p] = tx_data[i];
            p = p + 8'd1;
        end
        chk("wr_extra", 32'(wr_log.size()), 32'(rd_idx));
        chk("wr_ptr_end", 32'(bus.reg_addr), 32'(p));
        chk("wr_busy_end", 32'(bus.busy), 0);
    endtask

    // Set pointer, repeated START, read n bytes (ACK all but the last).
    task automatic read_txn(input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] b;
        int e0;
        e0 = ack_err_cnt;
        i2c_start();
        send_byte(i2c_addr_byte(7'h50, I2C_RW_WRITE), ack); chk("rd_waddr_ack", 32'(ack), 1);
        send_byte(ptr, ack); chk("rd_ptr_ack", 32'(ack), 1);
        i2c_start();
        send_byte(i2c_addr_byte(7'h50, I2C_RW_READ), ack); chk("rd_raddr_ack", 32'(ack), 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            chk("rd_data", 32'(b), 32'(model_mem[8'(ptr + i)]));
        end
        chk("rd_busy_nack", 32'(bus.busy), 0);
        clks(4);
        chk("rd_ack_err", 32'(ack_err_cnt - e0), 1);
        i2c_stop();
        chk("rd_ptr_end", 32'(bus.reg_addr), 32'(8'(ptr + n - 1)));
        chk("rd_no_write", 32'(wr_log.size()), 32'(rd_idx));
    endtask

    initial begin
        logic ack;
        int o0;
        clks(5);
        chk("rst_sda_oe", 32'(bus.sda_oe), 0);
        chk("rst_wr_en", 32'(bus.reg_wr_en), 0);
        chk("rst_reg_addr", 32'(bus.reg_addr), 0);
        chk("rst_wr_data", 32'(bus.reg_wr_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ack_err", 32'(bus.ack_err), 0);
        rst = 1'b0;
        clks(10);

        tx_data[0] = 8'h3C; tx_data[1] = 8'h5A;
        write_txn(8'hA0, 2);

        // Foreign address: no ACK, SDA never pulled, no writes.
        o0 = oe_cnt;
        i2c_start();
        send_byte(i2c_addr_byte(7'h51, I2C_RW_WRITE), ack); chk("ign_addr_ack", 32'(ack), 0);
        chk("ign_busy", 32'(bus.busy), 0);
        send_byte(8'h12, ack); chk("ign_data_ack", 32'(ack), 0);
        send_byte(8'h34, ack);
        i2c_stop();
        chk("ign_oe_cnt", 32'(oe_cnt - o0), 0);
        chk("ign_no_write", 32'(wr_log.size()), 32'(rd_idx));

        tx_data[0] = 8'hC3; tx_data[1] = 8'h7E;
        write_txn(8'h10, 2);
        read_txn(8'h10, 2);

        tx_data[0] = 8'h11; tx_data[1] = 8'h22;
        write_txn(8'hFF, 2);
        read_txn(8'hFF, 2);

        // STOP four bits into the second data byte.
        i2c_start();
        send_byte(i2c_addr_byte(7'h50, I2C_RW_WRITE), ack); chk("part_addr_ack", 32'(ack), 1);
        send_byte(8'h40, ack);
        send_byte(8'h99, ack); chk("part_d0_ack", 32'(ack), 1);
        send_bits(8'hF0, 4);
        i2c_stop();
        chk_wr(8'h40, 8'h99);
        model_mem[8'h40] = 8'h99;
        chk("part_no_write", 32'(wr_log.size()), 32'(rd_idx));
        chk("part_ptr", 32'(bus.reg_addr), 32'h41);
        chk("part_busy", 32'(bus.busy), 0);
        chk("part_sda_oe", 32'(bus.sda_oe), 0);

        // Reset while the address ACK is being driven.
        i2c_start();
        send_bits(i2c_addr_byte(7'h50, I2C_RW_WRITE), 8);
        clks(2); sda_m = 1'b1; clks(6);
        chk("rstack_pre_oe", 32'(bus.sda_oe), 1);
        chk("rstack_pre_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        clks(1);
        chk("rstack_sda_oe", 32'(bus.sda_oe), 0);
        chk("rstack_busy", 32'(bus.busy), 0);
        clks(3);
        rst = 1'b0;
        clks(5);
        tx_data[0] = 8'h55;
        write_txn(8'h20, 1);
        read_txn(8'h20, 1);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] ptr;
            int n;
            ptr = 8'($urandom);
            n = int'($urandom_range(4, 1));
            for (int i = 0; i < n; i++) tx_data[i] = 8'($urandom);
            write_txn(ptr, n);
            read_txn(ptr, n);
        end

        chk("sda_change_scl_high", 32'(glitch_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder on the same 2-wire bus our I2C master drives.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address and accepts a register-pointer byte followed by write data bytes, or returns read data from the pointer.
- Drives SDA only open-drain (pull-low enable) and exposes a simple synchronous port to an external 256-entry register file.

Parameters:
- SLV_ADDRESS, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be ≥ 16× SCL frequency.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  bus SCL level (asynchronous).
- sda_in  input  1  bus SDA level (asynchronous).
- sda_oe  output  1  1 = pull SDA low, 0 = release; never drives high.
- reg_wr_en  output  1  one-clk write strobe to the register file.
- reg_addr  output  8  current register pointer (write address and read address).
- reg_wr_data  output  8  byte written when reg_wr_en = 1.
- reg_rd_data  input  8  register file read data for reg_addr; combinational, valid same cycle.
- busy  output  1  1 from an address-matched START until STOP or NACK release.
- ack_err  output  1  one-clk pulse when the master NACKs a read byte.

Behaviour:
- Reset values: sda_oe=0, reg_wr_en=0, reg_addr=8'h00, reg_wr_data=8'h00, busy=0, ack_err=0, state=IDLE, bit counter=0.
- Sync and edge detection: SYNC_STAGES flops, then a 1-flop history register. scl_rise, scl_fall, START (sda falls while scl=1) and STOP (sda rises while scl=1) are single-clk pulses, 3 clk after the pin change.
- START and STOP are recognised in every state and override all other events in the same cycle.
  - START goes to ADDR (this is also a repeated START): bit counter cleared, sda_oe=0.
  - STOP goes to IDLE: sda_oe=0, busy=0.
- Data bits are sampled on scl_rise, MSB first, into an 8-bit shift register. The bit counter runs 0..7; the byte is complete on the 8th scl_rise.
- States:
  - IDLE: wait for START.
  - ADDR: on byte complete, compare [7:1] with SLV_ADDRESS.
    - Match: ADDR_ACK, busy=1, R/W bit latched.
    - Mismatch: IGNORE (no ACK, sda_oe stays 0 until START/STOP).
  - ADDR_ACK: sda_oe=1 from the next scl_fall until the following scl_fall. Then go to REG if W, or RDATA if R.
  - REG: byte complete loads reg_addr; go to REG_ACK, with ACK driven as in ADDR_ACK; then WDATA.
  - WDATA: byte complete gives reg_wr_data=byte and reg_wr_en=1 for exactly one clk at entry to WDATA_ACK. ACK is driven. On the ACK-ending scl_fall, reg_addr increments (8'hFF wraps to 8'h00); return to WDATA.
  - RDATA: on entry (at the scl_fall that ends the ACK), load the shift register from reg_rd_data. sda_oe = ~shift[7], updated on each scl_fall. After 8 bits, release SDA at the 8th scl_fall and go to RDATA_ACK.
  - RDATA_ACK: sample SDA on scl_rise.
    - 0 (ACK): increment reg_addr, go to RDATA.
    - 1 (NACK): pulse ack_err, sda_oe=0, go to IGNORE.
- busy=0 in IDLE and IGNORE.
- A STOP mid-byte discards the partial byte: no reg_wr_en, reg_addr unchanged.
- Synchronous rst mid-transfer returns to IDLE next clk and releases SDA immediately.
- sda_oe changes only on scl_fall (plus START/STOP/reset release), so SDA never changes while SCL is high.

Decomposition:
- Shared package i2c_pkg holds the state encoding (one-hot, 10 states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE) and the I2C_RW_READ/I2C_RW_WRITE constants. The master also uses this package.
- One sub-module, i2c_bus_sync: synchronisers plus edge/START/STOP pulse generation. The FSM and shift logic stay in i2c_target.

Test Plan:
- Write 0xA0 then 0x3C, 0x5A to target 0x50 -> ACK on 3 bytes; reg_wr_en pulses twice with (reg_addr, data) = (0xA0, 0x3C) and (0xA1, 0x5A); reg_addr=0xA2 after STOP.
- Address 0x51 write -> sda_oe stays 0 for the whole frame; busy=0; no reg_wr_en.
- Write ptr 0x10, repeated START, read 2 bytes with reg file mem[0x10]=0xC3, mem[0x11]=0x7E, master ACK then NACK -> SDA carries 0xC3, 0x7E; ack_err pulses once; busy=0 after NACK.
- Write ptr 0xFF, data 0x11, 0x22 -> writes to 0xFF then 0x00 (wrap).
- STOP after 4 data bits of the 2nd byte -> no write for the partial byte; state IDLE; sda_oe=0.
- rst asserted during ADDR_ACK with sda_oe=1 -> sda_oe=0 and busy=0 one clk later; the next valid frame is accepted normally.
